// File: rtl/ysyx_25040111_mem_arbiter.sv
// Two-master memory arbiter: ICache refill bursts and LSU single beats share one bridge port.
// Optional beat watchdog enabled by defining ARB_TIMEOUT_EN.
module ysyx_25040111_mem_arbiter #(
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ic_valid,
  input  logic [31:0] ic_addr,
  input  logic        ic_burst,
  input  logic [7:0]  ic_len,
  output logic        ic_ready,
  output logic [31:0] ic_rdata,
  output logic        ic_err,
  input  logic        lsu_valid,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic        mem_burst,
  output logic [7:0]  mem_len,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_last,
  input  logic        mem_err,
  output logic [1:0]  dbg_state
);

  // Handshake: requesters hold valid until their final ready/err pulse and drop it on that
  // same edge; mem_valid is a registered level that stays high from grant to final beat/err.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IC  = 2'd1,
    GNT_LSU = 2'd2
  } state_t;

  if (TMO_MAX >= (1 << TMO_W)) begin : g_tmo_chk
    $error("TMO_MAX does not fit in TMO_W bits");
  end

  state_t      state, next_state;
  logic        last_gnt_lsu;
  logic        gnt_ic, gnt_lsu;
  logic        done, abort, tmo_hit;
  logic        owner_ic, owner_lsu, granted;
  logic [31:0] addr_q, wdata_q;
  logic        burst_q, wen_q;
  logic [7:0]  len_q;
  logic [3:0]  wstrb_q;

  assign owner_ic  = (state == GNT_IC);
  assign owner_lsu = (state == GNT_LSU);
  assign granted   = owner_ic | owner_lsu;
  assign dbg_state = state;

`ifdef ARB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_MAX);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clock) begin
    if (reset || gnt_ic || gnt_lsu || mem_ready || !granted) tmo_cnt <= '0;
    else                                                   tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = granted && (tmo_cnt == TMO_LIM);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    next_state = state;
    gnt_ic     = 1'b0;
    gnt_lsu    = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        // Round-robin only matters on a tie: favour whoever was not served last.
        if (ic_valid && lsu_valid) begin
          gnt_ic  = last_gnt_lsu;
          gnt_lsu = !last_gnt_lsu;
        end else begin
          gnt_ic  = ic_valid;
          gnt_lsu = lsu_valid;
        end
        if (gnt_ic)  next_state = GNT_IC;
        if (gnt_lsu) next_state = GNT_LSU;
      end
      GNT_IC: begin
        abort = mem_err | tmo_hit;
        done  = mem_ready & mem_last & ~abort;
        if (abort || done) next_state = IDLE;
      end
      GNT_LSU: begin
        abort = mem_err | tmo_hit;
        done  = mem_ready & ~abort;
        if (abort || done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      mem_valid    <= 1'b0;
      last_gnt_lsu <= 1'b0;
      addr_q       <= '0;
      burst_q      <= 1'b0;
      len_q        <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      state     <= next_state;
      mem_valid <= (next_state != IDLE);
      if (granted && next_state == IDLE) last_gnt_lsu <= owner_lsu;
      // Fields are captured once; later requester changes are not seen until completion.
      if (gnt_ic) begin
        addr_q  <= ic_addr;
        burst_q <= ic_burst;
        len_q   <= ic_len;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wstrb_q <= '0;
      end else if (gnt_lsu) begin
        addr_q  <= lsu_addr;
        burst_q <= 1'b0;
        len_q   <= '0;
        wen_q   <= lsu_wen;
        wdata_q <= lsu_wdata;
        wstrb_q <= lsu_wstrb;
      end
    end
  end

  assign mem_addr  = granted ? addr_q  : '0;
  assign mem_burst = granted ? burst_q : 1'b0;
  assign mem_len   = granted ? len_q   : '0;
  assign mem_wen   = granted ? wen_q   : 1'b0;
  assign mem_wdata = granted ? wdata_q : '0;
  assign mem_wstrb = granted ? wstrb_q : '0;

  assign ic_ready  = owner_ic  & mem_ready & ~abort;
  assign lsu_ready = owner_lsu & mem_ready & ~abort;
  assign ic_err    = owner_ic  & abort;
  assign lsu_err   = owner_lsu & abort;
  assign ic_rdata  = ic_ready  ? mem_rdata : '0;
  assign lsu_rdata = lsu_ready ? mem_rdata : '0;

endmodule
